// File: rtl/mac_engine_mlane_pkg.sv
// Shared control/status types, state encoding and size defaults for the multi-lane MAC engine.
package mac_mlane_package;

    localparam int CNT_LEN        = 1024;
    localparam int MAX_DATA_WIDTH = 32;
    localparam int LEN_W          = $clog2(CNT_LEN) + 1;
    localparam int SHIFT_W        = $clog2(MAX_DATA_WIDTH);

    typedef struct packed {
        logic               clear;
        logic               enable;
        logic               simple_mult;
        logic               start;
        logic [LEN_W-1:0]   len;
        logic [SHIFT_W-1:0] shift;
    } ctrl_engine_mlane_t;

    typedef struct packed {
        logic             busy;
        logic [LEN_W-1:0] cnt;
        logic             acc_valid;
    } flags_engine_mlane_t;

    typedef enum logic [2:0] {
        IDLE,
        MULT,
        INIT,
        ACCUM,
        DRAIN,
        OUT
    } state_e;

endpackage

// File: rtl/mac_engine_mlane_lane.sv
// One MAC lane: registered product, wide accumulator, arithmetic shift and output reduction.
// Output reduction saturates when MAC_ENGINE_MLANE_SAT_EN is defined, otherwise wraps.
module mac_mlane_lane
    import mac_mlane_package::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(mac_mlane_package::CNT_LEN)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clr,
    input  logic                  load_mult,
    input  logic                  load_acc,
    input  logic                  add_acc,
    input  logic                  sel_acc,
    input  logic [SHIFT_W-1:0]    shift,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [DATA_WIDTH-1:0] c,
    output logic [DATA_WIDTH-1:0] d
);

    localparam int MW = 2*DATA_WIDTH;

    logic signed [MW-1:0]        a_ext, b_ext, r_mult;
    logic signed [ACC_WIDTH-1:0] r_acc, c_ext, mult_ext, res_wide, res_sh;

    assign a_ext    = {{DATA_WIDTH{a[DATA_WIDTH-1]}}, a};
    assign b_ext    = {{DATA_WIDTH{b[DATA_WIDTH-1]}}, b};
    assign c_ext    = {{(ACC_WIDTH-DATA_WIDTH){c[DATA_WIDTH-1]}}, c};
    assign mult_ext = {{(ACC_WIDTH-MW){r_mult[MW-1]}}, r_mult};

    // Accumulator lives in the c<<<shift fixed-point domain; products are aligned to it.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr) begin
            r_mult <= '0;
            r_acc  <= '0;
        end else begin
            if (load_mult)
                r_mult <= a_ext * b_ext;
            if (load_acc)
                r_acc <= c_ext <<< shift;
            else if (add_acc)
                r_acc <= r_acc + (mult_ext <<< shift);
        end
    end

    assign res_wide = sel_acc ? r_acc : mult_ext;
    assign res_sh   = res_wide >>> shift;

`ifdef MAC_ENGINE_MLANE_SAT_EN
    logic ovf;
    assign ovf = res_sh[ACC_WIDTH-1:DATA_WIDTH-1] !=
                 {(ACC_WIDTH-DATA_WIDTH+1){res_sh[ACC_WIDTH-1]}};

    always_comb begin
        d = res_sh[DATA_WIDTH-1:0];
        if (ovf)
            d = res_sh[ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                    : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
`else
    logic unused_hi;
    assign unused_hi = ^res_sh[ACC_WIDTH-1:DATA_WIDTH];
    assign d         = res_sh[DATA_WIDTH-1:0];
`endif

endmodule

// File: rtl/mac_engine_mlane.sv
// Multi-lane MAC engine top: shared FSM and beat counter driving NB_LANES mac_mlane_lane datapaths.
// Optional output saturation is selected with MAC_ENGINE_MLANE_SAT_EN.
module mac_engine_mlane
    import mac_mlane_package::*;
#(
    parameter int NB_LANES   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_LEN    = mac_mlane_package::CNT_LEN
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             test_mode_i,
    input  logic [NB_LANES*DATA_WIDTH-1:0]   a_i_data,
    input  logic                             a_i_valid,
    output logic                             a_i_ready,
    input  logic [NB_LANES*DATA_WIDTH-1:0]   b_i_data,
    input  logic                             b_i_valid,
    output logic                             b_i_ready,
    input  logic [NB_LANES*DATA_WIDTH-1:0]   c_i_data,
    input  logic                             c_i_valid,
    output logic                             c_i_ready,
    output logic [NB_LANES*DATA_WIDTH-1:0]   d_o_data,
    output logic [NB_LANES*DATA_WIDTH/8-1:0] d_o_strb,
    output logic                             d_o_valid,
    input  logic                             d_o_ready,
    input  ctrl_engine_mlane_t               ctrl_i,
    output flags_engine_mlane_t              flags_o
);

    localparam int ACC_WIDTH = 2*DATA_WIDTH + $clog2(CNT_LEN);

    state_e           state, next;
    logic [LEN_W-1:0] cnt;
    logic             mult_vld, ab_ready, c_rdy, d_vld;
    logic             cnt_done, cnt_last, consume, c_hs, add_acc;
    logic             unused_tm;

    assign unused_tm = test_mode_i;
    assign cnt_done  = (cnt == ctrl_i.len);
    assign cnt_last  = ((cnt + LEN_W'(1)) == ctrl_i.len);

    always_comb begin
        next     = state;
        ab_ready = 1'b0;
        c_rdy    = 1'b0;
        d_vld    = 1'b0;
        case (state)
            IDLE:
                if (ctrl_i.start) next = ctrl_i.simple_mult ? MULT : INIT;
            MULT: begin
                // a/b only advance when the result slot is free or draining this cycle
                ab_ready = !cnt_done && (!mult_vld || d_o_ready);
                d_vld    = mult_vld;
                if (cnt_done && (!mult_vld || d_o_ready)) next = IDLE;
            end
            INIT: begin
                c_rdy = 1'b1;
                if (c_i_valid) next = (ctrl_i.len == '0) ? OUT : ACCUM;
            end
            ACCUM: begin
                ab_ready = !cnt_done;
                if (a_i_valid && b_i_valid && !cnt_done && cnt_last) next = DRAIN;
            end
            DRAIN:
                next = OUT;
            OUT: begin
                d_vld = 1'b1;
                if (d_o_ready) next = IDLE;
            end
            default:
                next = IDLE;
        endcase
        if (!ctrl_i.enable) begin
            next     = state;
            ab_ready = 1'b0;
            c_rdy    = 1'b0;
            d_vld    = 1'b0;
        end
        if (ctrl_i.clear) next = IDLE;
    end

    assign consume = a_i_valid && b_i_valid && ab_ready;
    assign c_hs    = c_i_valid && c_rdy;
    assign add_acc = ctrl_i.enable && mult_vld && (state == ACCUM || state == DRAIN);

    always_ff @(posedge clk_i) begin
        if (!rst_ni || ctrl_i.clear) begin
            state    <= IDLE;
            cnt      <= '0;
            mult_vld <= 1'b0;
        end else if (ctrl_i.enable) begin
            state    <= next;
            mult_vld <= consume || (state == MULT && mult_vld && !d_o_ready);
            if (next == IDLE)
                cnt <= '0;
            else if (consume)
                cnt <= cnt + LEN_W'(1);
        end
    end

    for (genvar k = 0; k < NB_LANES; k++) begin : g_lane
        mac_mlane_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH)
        ) u_lane (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .clr       (ctrl_i.clear),
            .load_mult (consume),
            .load_acc  (c_hs),
            .add_acc   (add_acc),
            .sel_acc   (state == OUT),
            .shift     (ctrl_i.shift),
            .a         (a_i_data[k*DATA_WIDTH +: DATA_WIDTH]),
            .b         (b_i_data[k*DATA_WIDTH +: DATA_WIDTH]),
            .c         (c_i_data[k*DATA_WIDTH +: DATA_WIDTH]),
            .d         (d_o_data[k*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    assign a_i_ready = ab_ready;
    assign b_i_ready = ab_ready;
    assign c_i_ready = c_rdy;
    assign d_o_valid = d_vld;
    assign d_o_strb  = '1;

    assign flags_o.busy      = (state != IDLE);
    assign flags_o.cnt       = cnt;
    assign flags_o.acc_valid = (state == OUT);

endmodule

// File: doc/mac_engine_mlane.md
MAC_ENGINE_MLANE -- requirements
Module: mac_engine_mlane

Interface
REQ-001 The block SHALL have parameter NB_LANES, default 4, number of independent MAC lanes.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, signed operand/result width per lane.
REQ-003 The block SHALL have parameter CNT_LEN, default 1024, maximum scalar-product length.
REQ-004 The block SHALL have port clk_i, input, 1, the only clock.
REQ-005 The block SHALL have port rst_ni, input, 1, reset, synchronous and active-low.
REQ-006 The block SHALL have port test_mode_i, input, 1, test mode; functionally unused.
REQ-007 The block SHALL have port a_i, hwpe_stream sink, NB_LANES*DATA_WIDTH, operand A, lane k in bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 The block SHALL have ports b_i and c_i, hwpe_stream sink, NB_LANES*DATA_WIDTH, operand B and accumulator init C, same lane packing as a_i.
REQ-009 The block SHALL have port d_o, hwpe_stream source, NB_LANES*DATA_WIDTH, result; d_o.strb always all ones.
REQ-010 The block SHALL have port ctrl_i, input, ctrl_engine_mlane_t: fields clear, enable, simple_mult, start, len (clog2(CNT_LEN)+1 bits), shift (clog2(DATA_WIDTH) bits).
REQ-011 The block SHALL have port flags_o, output, flags_engine_mlane_t: fields busy, cnt, acc_valid.

Function
REQ-012 States SHALL be IDLE, MULT, INIT, ACCUM, DRAIN, OUT; reset and ctrl_i.clear force IDLE on the next edge, discarding all in-flight data.
REQ-013 IDLE -> MULT on start with simple_mult=1; IDLE -> INIT on start with simple_mult=0; start ignored outside IDLE; start with enable=0 ignored.
REQ-014 a_i and b_i SHALL be joined: a beat is consumed only when a_i.valid and b_i.valid and the stage is ready; a_i.ready equals b_i.ready.
REQ-015 MULT: per lane product a*b (2*DATA_WIDTH signed) registered in r_mult; d_o.valid asserted the cycle after consumption with data = r_mult >>> shift; latency 1 cycle; sustains one beat per cycle when d_o.ready=1.
REQ-016 MULT backpressure: while d_o.valid and !d_o.ready, r_mult and d_o.data SHALL hold and a_i/b_i.ready SHALL be 0.
REQ-017 MULT returns to IDLE when len beats have been output; len=0 in MULT returns to IDLE immediately without output.
REQ-018 INIT: c_i.ready=1; on c_i handshake, r_acc per lane = sign-extend(c) <<< shift, width 2*DATA_WIDTH+clog2(CNT_LEN); -> ACCUM, or -> OUT if len=0.
REQ-019 ACCUM: each consumed a/b beat registers product in r_mult; r_acc += r_mult one cycle later; cnt increments per consumed beat; after len beats -> DRAIN.
REQ-020 DRAIN: one cycle, adds final r_mult; -> OUT.
REQ-021 OUT: d_o.valid=1, data = r_acc >>> shift reduced to DATA_WIDTH per REQ-027; on d_o handshake -> IDLE, cnt cleared.
REQ-022 c_i.ready SHALL be 0 outside INIT; a_i/b_i.ready SHALL be 0 outside MULT and ACCUM.
REQ-023 flags_o.busy = state != IDLE; flags_o.cnt = beats consumed in current job; flags_o.acc_valid = 1 in OUT only.
REQ-024 enable=0 SHALL freeze all state and registers and deassert all ready/valid outputs.

Reset
REQ-025 On rst_ni=0 at a clock edge: state IDLE, r_mult, r_acc, cnt zero; d_o.valid, all ready outputs, flags_o all zero.
REQ-026 Reset mid-job SHALL produce no further d_o beat from that job.

Configuration
REQ-027 With MAC_ENGINE_MLANE_SAT_EN defined, each lane output SHALL saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; without it, the lower DATA_WIDTH bits are taken (wrap).

Structure
REQ-028 ctrl_engine_mlane_t, flags_engine_mlane_t, the state enum and CNT_LEN default SHALL live in mac_mlane_package.
REQ-029 The per-lane multiplier, accumulator and shift/saturate datapath SHALL be sub-module mac_mlane_lane, instantiated NB_LANES times; the FSM and counter are shared.

Verification
REQ-030 simple_mult, len=3, shift=0, lane0 a={2,-3,7}, b={5,4,-1} -> d lane0 {10,-12,-7}, one per cycle, then IDLE.
REQ-031 scalar_prod, len=4, shift=2, c=1, a=b={1,2,3,4} -> single d = 31 (4+30*4=124, >>>2), acc_valid=1 for that beat only.
REQ-032 d_o.ready held 0 for 5 cycles in MULT -> d_o.data stable, a_i.ready=0, no beat lost or duplicated.
REQ-033 DATA_WIDTH=8, a=b=100, shift=0 -> d=127 with MAC_ENGINE_MLANE_SAT_EN, 16 (10000 mod 256) without.
REQ-034 clear asserted after 2 of 4 ACCUM beats -> IDLE next cycle, no d_o beat, new job then yields correct result.
REQ-035 scalar_prod len=0, c=-5, shift=0 -> d=-5 with no a/b consumed.
